// File: rtl/data_mem_arb_pkg.sv
// Shared types and default sizes for the data-memory arbiter.
// The optional bounds check is enabled by defining DATA_MEM_ARB_BOUNDS_EN.
package data_mem_arb_pkg;

    localparam int unsigned DEF_ADDR_W    = 16;
    localparam int unsigned DEF_DATA_W    = 16;
    localparam int unsigned DEF_MEM_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // Owner value doubles as the bit index into the {dma, cpu} request vector.
    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin picker: on a tie, the requester not granted last time wins.
module rr_arbiter2
    import data_mem_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  owner_e     i_last_grant,
    output owner_e     o_grant,
    output logic       o_grant_valid
);

    always_comb begin
        o_grant_valid = |i_req;
        o_grant       = OWN_CPU;
        case (i_req)
            2'b01:   o_grant = OWN_CPU;
            2'b10:   o_grant = OWN_DMA;
            2'b11:   o_grant = owner_e'(~i_last_grant);
            default: o_grant = OWN_CPU;
        endcase
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing single-port data memory between CPU and DMA requesters.
// Define DATA_MEM_ARB_BOUNDS_EN to add the out-of-range check and the err output.
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned MEM_DEPTH = DEF_MEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] mem_access_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_en,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              busy
`ifdef DATA_MEM_ARB_BOUNDS_EN
    ,
    output logic              err
`endif
);

    state_e            r_state;
    state_e            w_state_next;
    owner_e            r_last_grant;
    owner_e            r_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;

    owner_e            w_grant;
    logic              w_grant_valid;
    logic              w_grant_take;
    logic              w_win_we;
    logic [ADDR_W-1:0] w_win_addr;
    logic [DATA_W-1:0] w_win_wdata;
    logic              w_blocked;

    rr_arbiter2 u_rr_arbiter2 (
        .i_req         ({dma_req, cpu_req}),
        .i_last_grant  (r_last_grant),
        .o_grant       (w_grant),
        .o_grant_valid (w_grant_valid)
    );

    assign w_grant_take = (r_state == IDLE) && w_grant_valid;
    assign w_win_we     = (w_grant == OWN_DMA) ? dma_we    : cpu_we;
    assign w_win_addr   = (w_grant == OWN_DMA) ? dma_addr  : cpu_addr;
    assign w_win_wdata  = (w_grant == OWN_DMA) ? dma_wdata : cpu_wdata;

`ifdef DATA_MEM_ARB_BOUNDS_EN
    logic r_oob;
    logic w_oob;

    assign w_oob = (64'(w_win_addr) >= 64'(MEM_DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_oob <= 1'b0;
        end else if (w_grant_take) begin
            r_oob <= w_oob;
        end
    end

    assign w_blocked = r_oob;
    assign err       = (r_state == RESP) && r_oob;
`else
    logic w_unused_depth;

    assign w_unused_depth = (MEM_DEPTH == 0);
    assign w_blocked      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_last_grant <= OWN_DMA;
        end else begin
            r_state <= w_state_next;
            if (r_state == ACCESS) begin
                r_last_grant <= r_owner;
            end
        end
    end

    // Request fields are captured once at grant; later input changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner <= OWN_CPU;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else if (w_grant_take) begin
            r_owner <= w_grant;
            r_we    <= w_win_we;
            r_addr  <= w_win_addr;
            r_wdata <= w_win_wdata;
        end else if (r_state == ACCESS) begin
            r_rdata <= (r_we || w_blocked) ? '0 : mem_read_data;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        mem_access_addr = '0;
        mem_write_data  = '0;
        mem_write_en    = 1'b0;
        mem_read        = 1'b0;
        cpu_ack         = 1'b0;
        cpu_rdata       = '0;
        dma_ack         = 1'b0;
        dma_rdata       = '0;
        busy            = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (w_grant_valid) begin
                    w_state_next = ACCESS;
                end
            end
            ACCESS: begin
                mem_access_addr = r_addr;
                mem_write_data  = r_wdata;
                mem_write_en    = r_we & ~w_blocked;
                mem_read        = ~r_we & ~w_blocked;
                w_state_next    = RESP;
            end
            RESP: begin
                if (r_owner == OWN_CPU) begin
                    cpu_ack   = 1'b1;
                    cpu_rdata = r_rdata;
                end else begin
                    dma_ack   = 1'b1;
                    dma_rdata = r_rdata;
                end
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed self-checking bench for data_mem_arbiter with a behavioural data memory.
module tb_data_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_ack;
    logic [15:0] cpu_rdata;
    logic        dma_req;
    logic        dma_we;
    logic [15:0] dma_addr;
    logic [15:0] dma_wdata;
    logic        dma_ack;
    logic [15:0] dma_rdata;
    logic [15:0] mem_access_addr;
    logic [15:0] mem_write_data;
    logic        mem_write_en;
    logic        mem_read;
    logic [15:0] mem_read_data;
    logic        busy;
`ifdef DATA_MEM_ARB_BOUNDS_EN
    logic        err;
`endif

    int tests;
    int fails;
    int wr_cnt;

    logic [15:0] mem [32];
    logic        pre_en;
    logic [4:0]  pre_addr;
    logic [15:0] pre_data;

    data_mem_arbiter #(
        .ADDR_W    (16),
        .DATA_W    (16),
        .MEM_DEPTH (16)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cpu_req         (cpu_req),
        .cpu_we          (cpu_we),
        .cpu_addr        (cpu_addr),
        .cpu_wdata       (cpu_wdata),
        .cpu_ack         (cpu_ack),
        .cpu_rdata       (cpu_rdata),
        .dma_req         (dma_req),
        .dma_we          (dma_we),
        .dma_addr        (dma_addr),
        .dma_wdata       (dma_wdata),
        .dma_ack         (dma_ack),
        .dma_rdata       (dma_rdata),
        .mem_access_addr (mem_access_addr),
        .mem_write_data  (mem_write_data),
        .mem_write_en    (mem_write_en),
        .mem_read        (mem_read),
        .mem_read_data   (mem_read_data),
        .busy            (busy)
`ifdef DATA_MEM_ARB_BOUNDS_EN
        ,
        .err             (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory model: combinational read, synchronous write, bench preload port.
    assign mem_read_data = mem[mem_access_addr[4:0]];

    always @(posedge clk) begin
        if (pre_en) begin
            mem[pre_addr] <= pre_data;
        end else if (mem_write_en) begin
            mem[mem_access_addr[4:0]] <= mem_write_data;
        end
        if (mem_write_en) begin
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [4:0] a, input logic [15:0] d);
        pre_en   = 1'b1;
        pre_addr = a;
        pre_data = d;
        tick();
        pre_en   = 1'b0;
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        wr_cnt    = 0;
        pre_en    = 1'b0;
        pre_addr  = '0;
        pre_data  = '0;
        rst_n     = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        dma_req   = 1'b0;
        dma_we    = 1'b0;
        dma_addr  = '0;
        dma_wdata = '0;

        preload(5'd3, 16'd12);
        preload(5'd4, 16'd26);
        preload(5'd5, 16'd0);
        preload(5'd7, 16'd99);
        preload(5'd9, 16'd0);

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_cpu_ack", cpu_ack, 0);
        check("rst_dma_ack", dma_ack, 0);
        check("rst_mem_we", mem_write_en, 0);
        check("rst_mem_rd", mem_read, 0);
        check("rst_mem_addr", mem_access_addr, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        rst_n = 1'b1;
        tick();
        check("idle_busy", busy, 0);

        // Single CPU read of word 3
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 16'd3;
        tick();
        check("rd_busy", busy, 1);
        check("rd_mem_read", mem_read, 1);
        check("rd_mem_we", mem_write_en, 0);
        check("rd_mem_addr", mem_access_addr, 3);
        check("rd_early_ack", cpu_ack, 0);
        tick();
        check("rd_cpu_ack", cpu_ack, 1);
        check("rd_cpu_rdata", cpu_rdata, 12);
        check("rd_dma_ack", dma_ack, 0);
        check("rd_mem_read_off", mem_read, 0);
        cpu_req = 1'b0;
        tick();
        check("rd_ack_drop", cpu_ack, 0);
        check("rd_idle", busy, 0);

        // DMA write 0x00AA to word 5, then CPU read back
        dma_req   = 1'b1;
        dma_we    = 1'b1;
        dma_addr  = 16'd5;
        dma_wdata = 16'h00AA;
        tick();
        check("wr_mem_we", mem_write_en, 1);
        check("wr_mem_rd", mem_read, 0);
        check("wr_mem_addr", mem_access_addr, 5);
        check("wr_mem_data", mem_write_data, 16'h00AA);
        tick();
        check("wr_mem_we_off", mem_write_en, 0);
        check("wr_dma_ack", dma_ack, 1);
        check("wr_dma_rdata", dma_rdata, 0);
        check("wr_cpu_ack", cpu_ack, 0);
        check("wr_one_cycle", wr_cnt, 1);
        dma_req = 1'b0;
        dma_we  = 1'b0;
        tick();
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 16'd5;
        tick();
        tick();
        check("rb_cpu_ack", cpu_ack, 1);
        check("rb_cpu_rdata", cpu_rdata, 16'h00AA);
        cpu_req = 1'b0;
        tick();

        // Simultaneous requests from reset: CPU, DMA, CPU, DMA every 3 cycles
        rst_n = 1'b0;
        tick();
        rst_n    = 1'b1;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 16'd3;
        dma_req  = 1'b1;
        dma_we   = 1'b0;
        dma_addr = 16'd5;
        for (int i = 1; i <= 12; i++) begin
            tick();
            check($sformatf("rr_cpu_ack_c%0d", i), cpu_ack, (i == 2 || i == 8) ? 1 : 0);
            check($sformatf("rr_dma_ack_c%0d", i), dma_ack, (i == 5 || i == 11) ? 1 : 0);
            if (i == 2) check("rr_cpu_rdata", cpu_rdata, 12);
            if (i == 5) check("rr_dma_rdata", dma_rdata, 16'h00AA);
        end
        cpu_req = 1'b0;
        dma_req = 1'b0;
        tick();
        check("rr_idle", busy, 0);

        // Reset asserted during the ACCESS cycle of a write
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 16'd9;
        cpu_wdata = 16'h0055;
        tick();
        check("mr_mem_we", mem_write_en, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_mem_we_async", mem_write_en, 0);
        check("mr_busy_async", busy, 0);
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        tick();
        check("mr_no_ack", cpu_ack, 0);
        rst_n = 1'b1;
        tick();
        tick();
        check("mr_no_ack_late", cpu_ack, 0);
        check("mr_busy", busy, 0);
        check("mr_mem_untouched", mem[9], 0);

        // Input change after grant is ignored
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 16'd4;
        tick();
        cpu_addr = 16'd7;
        check("ic_mem_addr", mem_access_addr, 4);
        tick();
        check("ic_cpu_ack", cpu_ack, 1);
        check("ic_cpu_rdata", cpu_rdata, 26);
        cpu_req = 1'b0;
        tick();

        // Lone requester wins back-to-back
        cpu_req  = 1'b1;
        cpu_addr = 16'd3;
        tick();
        tick();
        check("b2b_ack1", cpu_ack, 1);
        tick();
        check("b2b_gap", busy, 0);
        tick();
        check("b2b_mem_read", mem_read, 1);
        check("b2b_mem_addr", mem_access_addr, 3);
        tick();
        check("b2b_ack2", cpu_ack, 1);
        check("b2b_rdata2", cpu_rdata, 12);
        check("b2b_dma_ack", dma_ack, 0);
        cpu_req = 1'b0;
        tick();

`ifdef DATA_MEM_ARB_BOUNDS_EN
        // Out-of-range write is suppressed and flagged
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 16'd20;
        cpu_wdata = 16'h0077;
        tick();
        check("oob_mem_we", mem_write_en, 0);
        check("oob_mem_rd", mem_read, 0);
        check("oob_err_early", err, 0);
        tick();
        check("oob_cpu_ack", cpu_ack, 1);
        check("oob_err", err, 1);
        check("oob_rdata", cpu_rdata, 0);
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        tick();
        check("oob_err_clear", err, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
